// File: rtl/debug_text_writer_pkg.sv
// Shared definitions for the debug text writer: line layout, ASCII
// constants, FSM state encoding and small character helpers.
package debug_text_writer_pkg;

  // Line layout: 7 label characters, ':' and ' ', then 8 hex digits.
  localparam int LABEL_CHARS = 7;
  localparam int SEP_CHARS   = 2;
  localparam int HEX_CHARS   = 8;
  localparam int ENTRY_CHARS = LABEL_CHARS + SEP_CHARS + HEX_CHARS;

  // Character position of the first hex digit within a line.
  localparam int HEX_FIRST = LABEL_CHARS + SEP_CHARS;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_A_M10 = 8'h37;  // 'A' - 10

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EMIT   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // Unused label bytes are zero and are shown as blanks.
  function automatic logic [7:0] label_char(input logic [7:0] b);
    return (b == 8'h00) ? ASCII_SPACE : b;
  endfunction

endpackage

// File: rtl/debug_text_writer_hex_to_ascii.sv
// Combinational nibble to uppercase ASCII hex digit.
module hex_to_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);
  import debug_text_writer_pkg::*;

  // 0-9 map to '0'..'9', 10-15 map to 'A'..'F'.
  always_comb begin
    if (nibble < 4'd10) ascii = ASCII_ZERO + {4'd0, nibble};
    else                ascii = ASCII_A_M10 + {4'd0, nibble};
  end

endmodule

// File: rtl/debug_text_writer.sv
// Debug text writer: sweeps the probe selector, formats each entry as
// "label: XXXXXXXX" and streams the characters to the text buffer.
//
// Write port handshake: wr_valid is raised while a character is offered and
// wr_addr/wr_data stay constant until the cycle in which wr_ready is also
// high; a character transfers on a rising edge with wr_valid && wr_ready.
// wr_valid never drops while a character is pending.
module debug_text_writer
  import debug_text_writer_pkg::*;
#(
  parameter int NUM_ENTRIES = 32,
  parameter int ROWS        = 16,
  parameter int COLS        = 80,
  parameter int ENTRY_W     = 20,
  parameter int ADDR_W      = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [6:0]        debug_addr,
  input  logic [31:0]       debug_data,
  input  logic [55:0]       debug_label,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  state_t      state;
  state_t      state_next;

  logic [6:0]  index;      // current probe entry, also drives debug_addr
  logic [4:0]  k;          // character position within the line
  logic        pending;    // start seen while a sweep was running
  logic [31:0] data_q;
  logic [55:0] label_q;

  logic        last_char;
  logic        last_entry;
  logic        xfer;

  logic [7:0]  label_byte;
  logic [3:0]  nibble;
  logic [7:0]  hex_char;
  logic [7:0]  char_cur;
  logic [ADDR_W-1:0] addr_cur;

  assign last_char  = (k == 5'(ENTRY_CHARS - 1));
  assign last_entry = (index == 7'(NUM_ENTRIES - 1));
  assign xfer       = (state == ST_EMIT) && wr_ready;
  assign debug_addr = index;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic: one FETCH cycle per entry, then 17 accepted characters.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start || pending) state_next = ST_FETCH;
      ST_FETCH:  state_next = ST_EMIT;
      ST_EMIT: begin
        if (xfer && last_char) state_next = last_entry ? ST_FINISH : ST_FETCH;
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Sweep datapath: entry index, character index, capture and pending flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index   <= '0;
      k       <= '0;
      pending <= 1'b0;
      data_q  <= '0;
      label_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          pending <= 1'b0;
          if (start || pending) index <= '0;
        end
        ST_FETCH: begin
          data_q  <= debug_data;
          label_q <= debug_label;
          k       <= '0;
        end
        ST_EMIT: begin
          if (wr_ready) begin
            k <= k + 5'd1;
            if (last_char && !last_entry) index <= index + 7'd1;
          end
        end
        default: ;
      endcase
      // Requests arriving mid-sweep (including FINISH) collapse into one.
      if (start && (state != ST_IDLE)) pending <= 1'b1;
    end
  end

  // Pick the label byte or data nibble addressed by the character index.
  always_comb begin
    label_byte = 8'h00;
    nibble     = 4'h0;
    for (int i = 0; i < LABEL_CHARS; i++) begin
      if (k == 5'(i)) label_byte = label_q[8*(LABEL_CHARS-1-i) +: 8];
    end
    for (int i = 0; i < HEX_CHARS; i++) begin
      if (k == 5'(HEX_FIRST + i)) nibble = data_q[4*(HEX_CHARS-1-i) +: 4];
    end
  end

  hex_to_ascii u_hex (
    .nibble (nibble),
    .ascii  (hex_char)
  );

  // Character for position k of the line.
  always_comb begin
    if (k < 5'(LABEL_CHARS))          char_cur = label_char(label_byte);
    else if (k == 5'(LABEL_CHARS))     char_cur = ASCII_COLON;
    else if (k == 5'(LABEL_CHARS + 1)) char_cur = ASCII_SPACE;
    else                               char_cur = hex_char;
  end

  // Entries fill a column block top to bottom, then move right by ENTRY_W.
  always_comb begin
    addr_cur = ADDR_W'((index % ROWS) * COLS + (index / ROWS) * ENTRY_W + k);
  end

  // Output decode from state; write fields read zero when nothing is offered.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    case (state)
      ST_FETCH:  busy = 1'b1;
      ST_EMIT: begin
        busy     = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = addr_cur;
        wr_data  = char_cur;
      end
      ST_FINISH: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_debug_text_writer.sv
// Bench for debug_text_writer: random probe tables and write-ready patterns,
// expected character stream built from the line format, text image checks.
module tb_debug_text_writer;

  localparam int NUM_ENTRIES = 32;
  localparam int ROWS        = 16;
  localparam int COLS        = 80;
  localparam int ENTRY_W     = 20;
  localparam int ADDR_W      = 12;
  localparam int W           = ADDR_W + 8;
  localparam int LINE        = 17;
  localparam int SWEEP_W     = NUM_ENTRIES * LINE;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              busy;
  logic              done;
  logic [6:0]        debug_addr;
  logic [31:0]       debug_data;
  logic [55:0]       debug_label;
  logic              wr_valid;
  logic              wr_ready = 1'b1;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  logic [31:0] data_tab  [128];
  logic [55:0] label_tab [128];

  assign debug_data  = data_tab[debug_addr];
  assign debug_label = label_tab[debug_addr];

  debug_text_writer #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .ROWS        (ROWS),
    .COLS        (COLS),
    .ENTRY_W     (ENTRY_W),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .debug_addr  (debug_addr),
    .debug_data  (debug_data),
    .debug_label (debug_label),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data)
  );

  // Clock and edge counter: cyc == n between edge n and edge n+1.
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state.
  logic [W-1:0] exp_q[$];
  logic [7:0]   screen [4096];
  int           done_cycles[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           xfer_cnt = 0;
  int           ready_mode = 0;   // 0 always ready, 1 targeted stall, 2 random
  int           stall_addr = 0;
  int           stall_left = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: the text line for an entry, built as a string.
  function automatic logic [7:0] model_char(input int e, input int k);
    string s;
    string hexd;
    logic [7:0] b;
    hexd = "0123456789ABCDEF";
    s = "";
    for (int i = 6; i >= 0; i--) begin
      b = label_tab[e][8*i +: 8];
      if (b == 8'h00) b = 8'h20;
      s = {s, $sformatf("%c", b)};
    end
    s = {s, ": "};
    for (int i = 7; i >= 0; i--) s = {s, $sformatf("%c", hexd[data_tab[e][4*i +: 4]])};
    return s[k];
  endfunction

  function automatic int model_addr(input int e, input int k);
    return (e % ROWS) * COLS + (e / ROWS) * ENTRY_W + k;
  endfunction

  task automatic push_sweep();
    for (int e = 0; e < NUM_ENTRIES; e++)
      for (int k = 0; k < LINE; k++)
        exp_q.push_back({ADDR_W'(model_addr(e, k)), model_char(e, k)});
  endtask

  task automatic load_tables();
    for (int i = 0; i < 128; i++) begin
      data_tab[i] = $urandom;
      for (int b = 0; b < 7; b++)
        label_tab[i][8*b +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'(8'h61 + $urandom_range(0, 25));
    end
    label_tab[0]  = 56'h7063;    data_tab[0]  = 32'h00001A2C;  // "pc"
    label_tab[17] = 56'h6137;    data_tab[17] = 32'hDEADBEEF;  // "a7"
    label_tab[26] = 56'h733130;                                // "s10"
    label_tab[31] = 56'h7436;                                  // "t6"
  endtask

  task automatic begin_sweep();
    load_tables();
    for (int i = 0; i < 4096; i++) screen[i] = 8'h00;
    xfer_cnt = 0;
    done_cycles.delete();
  endtask

  // One cycle: check offered write, choose wr_ready, account transfer.
  task automatic step();
    @(negedge clk);
    if (wr_valid) begin
      if (exp_q.size() == 0) check("spurious_wr_valid", 64'(wr_valid), 64'(0));
      else begin
        check("wr_addr", 64'(wr_addr), 64'(exp_q[0][W-1:8]));
        check("wr_data", 64'(wr_data), 64'(exp_q[0][7:0]));
      end
    end
    if (done) begin
      done_cycles.push_back(cyc);
      check("busy_at_done", 64'(busy), 64'(0));
    end
    case (ready_mode)
      1: begin
        if (wr_valid && (int'(wr_addr) == stall_addr) && stall_left > 0) begin
          wr_ready = 1'b0;
          stall_left--;
        end else wr_ready = 1'b1;
      end
      2: wr_ready = ($urandom_range(0, 3) != 0);
      default: wr_ready = 1'b1;
    endcase
    if (wr_valid && wr_ready) begin
      screen[wr_addr] = wr_data;
      xfer_cnt++;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  // Raise start so that the next rising edge samples it; s is that edge.
  task automatic pulse_start(output int s);
    start = 1'b1;
    s = cyc + 1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_dones(input int n, input int budget);
    int b;
    b = 0;
    while (done_cycles.size() < n && b < budget) begin
      step();
      b++;
    end
    check("done_count_reached", 64'(done_cycles.size()), 64'(n));
  endtask

  task automatic check_text(input string name, input int base, input string lit);
    for (int i = 0; i < lit.len(); i++) check(name, 64'(screen[base + i]), 64'(lit[i]));
  endtask

  task automatic end_of_sweep(input int nsweeps);
    check("transfer_count", 64'(xfer_cnt), 64'(SWEEP_W * nsweeps));
    check("exp_queue_drained", 64'(exp_q.size()), 64'(0));
  endtask

  // Two sweeps: extra start pulses at offsets off_a/off_b (0 = unused).
  task automatic double_sweep(input int off_a, input int off_b);
    int s;
    int d;
    begin_sweep();
    ready_mode = 0;
    push_sweep();
    push_sweep();
    pulse_start(s);
    while (cyc < s + 578 && cyc < s + 2000) begin
      if ((off_a > 0 && cyc == s + off_a - 1) || (off_b > 0 && cyc == s + off_b - 1)) pulse_start(d);
      else step();
    end
    check("second_fetch_addr", 64'(debug_addr), 64'(0));
    check("second_fetch_busy", 64'(busy), 64'(1));
    check("second_fetch_valid", 64'(wr_valid), 64'(0));
    wait_dones(2, 1500);
    repeat (40) step();
    check("done_pulses_total", 64'(done_cycles.size()), 64'(2));
    if (done_cycles.size() >= 2) begin
      check("first_done_cycle", 64'(done_cycles[0]), 64'(s + 576));
      check("second_done_cycle", 64'(done_cycles[1]), 64'(s + 1154));
    end
    end_of_sweep(2);
  endtask

  initial begin
    int s;
    string pin;

    // Reset state.
    load_tables();
    repeat (3) step();
    check("rst_wr_valid", 64'(wr_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_debug_addr", 64'(debug_addr), 64'(0));
    check("rst_wr_addr", 64'(wr_addr), 64'(0));
    check("rst_wr_data", 64'(wr_data), 64'(0));
    rst = 1'b0;
    repeat (2) step();

    // Pin the model against hand-derived lines and addresses.
    pin = "     pc: 00001A2C";
    for (int k = 0; k < LINE; k++) check("model_line0", 64'(model_char(0, k)), 64'(pin[k]));
    check("model_addr17", 64'(model_addr(17, 0)), 64'(100));
    check("model_addr31", 64'(model_addr(31, 16)), 64'(1236));

    // Sweep with wr_ready held high.
    begin_sweep();
    ready_mode = 0;
    push_sweep();
    pulse_start(s);
    check("fetch_busy", 64'(busy), 64'(1));
    check("fetch_debug_addr", 64'(debug_addr), 64'(0));
    check("fetch_wr_valid", 64'(wr_valid), 64'(0));
    wait_dones(1, 1200);
    if (done_cycles.size() >= 1) check("done_cycle", 64'(done_cycles[0]), 64'(s + 576));
    repeat (3) step();
    end_of_sweep(1);
    check_text("text_entry0", 0, "     pc: 00001A2C");
    check_text("text_entry17", 100, "     a7: DEADBEEF");
    check_text("text_entry26", 820, "    s10:");
    check_text("text_entry31", 1220, "     t6: ");

    // Three-cycle stall while k=9 of entry 3 is offered.
    begin_sweep();
    ready_mode = 1;
    stall_addr = model_addr(3, 9);
    stall_left = 3;
    push_sweep();
    pulse_start(s);
    wait_dones(1, 1200);
    if (done_cycles.size() >= 1) check("stall_done_cycle", 64'(done_cycles[0]), 64'(s + 579));
    repeat (3) step();
    end_of_sweep(1);

    // Random backpressure.
    begin_sweep();
    ready_mode = 2;
    push_sweep();
    pulse_start(s);
    wait_dones(1, 3000);
    repeat (3) step();
    end_of_sweep(1);
    check_text("rand_text_entry17", 100, "     a7: DEADBEEF");
    ready_mode = 0;

    // Restarts requested mid-sweep and during FINISH.
    double_sweep(100, 300);
    double_sweep(577, 0);

    // Asynchronous reset in the middle of entry 5.
    begin_sweep();
    push_sweep();
    pulse_start(s);
    while (cyc < s + 95) step();
    #1 rst = 1'b1;
    #1;
    check("async_rst_wr_valid", 64'(wr_valid), 64'(0));
    check("async_rst_busy", 64'(busy), 64'(0));
    check("async_rst_debug_addr", 64'(debug_addr), 64'(0));
    exp_q.delete();
    repeat (5) step();
    rst = 1'b0;
    repeat (2) step();
    begin_sweep();
    push_sweep();
    pulse_start(s);
    wait_dones(1, 1200);
    if (done_cycles.size() >= 1) check("post_rst_done_cycle", 64'(done_cycles[0]), 64'(s + 576));
    repeat (3) step();
    end_of_sweep(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
